rd_ptr_empty: RTL and testbench
===============================

Name: rd_ptr_empty

Overview:
- Read-side pointer and empty-flag controller for the dual-clock FIFO; the reader counterpart of the write-side full logic.
- Internally synchronizes the Gray write pointer into the read clock domain.
- Advances the binary/Gray read pointer on accepted reads and produces the RAM read address, empty, almost_empty, fill count and a read strobe.
- Its Gray output rd_ptr_rd feeds the write-domain synchronizer.

Parameters:
- DEPTH, 7, address width; FIFO holds 2^DEPTH entries; pointers are DEPTH+1 bits.
- SYNC_STAGES, 2, flops in the write-pointer synchronizer chain; legal values are 2 or 3.
- AE_LEVEL, 2, almost_empty asserts when the fill count is <= AE_LEVEL.

Ports:
- clk_in  in  1  read-domain clock
- reset  in  1  asynchronous, active-low reset
- rd_en  in  1  read request from the consumer
- wr_ptr_wr  in  DEPTH+1  Gray write pointer, launched from the write clock domain
- rd_ptr_rd  out  DEPTH+1  registered Gray read pointer, sent to the write domain
- rd_addr  out  DEPTH  RAM read address, equal to binary read pointer [DEPTH-1:0]
- rd_fire  out  1  combinational rd_en & ~empty; drives the RAM read enable
- empty  out  1  registered empty flag
- almost_empty  out  1  registered, fill count <= AE_LEVEL
- rd_count  out  DEPTH+1  registered fill level as seen by the read domain, range 0..2^DEPTH
- underflow  out  1  sticky read-while-empty flag (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low, clock clk_in. On reset all synchronizer flops, rd_bin, rd_ptr_rd and rd_count go to 0; empty=1, almost_empty=1, underflow=0. The write side must be reset in the same window.
- Synchronizer: wr_ptr_wr passes through SYNC_STAGES flops (stage1 <= wr_ptr_wr, stageN <= stageN-1), with no logic between stages. wsync is the last stage.
- wbin = Gray-to-binary(wsync), computed by XOR prefix from the MSB.
- Read acceptance: rd_fire = rd_en & ~empty.
  - rd_bin_next = rd_bin + rd_fire, modulo 2^(DEPTH+1).
  - rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next.
  - Every edge registers rd_bin <= rd_bin_next and rd_ptr_rd <= rd_gray_next.
- empty <= (rd_gray_next == wsync). The comparison uses the full DEPTH+1 bits, so the MSB distinguishes laps.
- rd_count <= wbin - rd_bin_next, modulo 2^(DEPTH+1).
- almost_empty <= (wbin - rd_bin_next) <= AE_LEVEL.
- Latency: a write-pointer change appears at wsync after SYNC_STAGES edges. empty deasserts and rd_count updates on the following edge, i.e. edge SYNC_STAGES+1 after the wr_ptr_wr change.
- Last entry read: empty asserts on the same edge that accepts the read (no bubble), and no further pointer advance occurs.
- Read while empty: rd_fire=0, pointers hold, no RAM read. Sets underflow when the feature is enabled.
- Simultaneous last read and new write arriving at wsync: empty evaluates against the new wsync, so it stays 0 if wbin != rd_bin_next.
- Wrap-around: binary pointer rolls from 2^(DEPTH+1)-1 to 0; Gray pointer changes exactly one bit per increment, including at the wrap.
- rd_addr is combinational from rd_bin only; it is never glitched by rd_en.
- Reset mid-operation: outputs go to reset values immediately, without waiting for a clock. Pointer state and buffered data are discarded.

Optional Feature:
- Macro: RD_UNDERFLOW_EN.
- Defined: underflow is a register set when rd_en & empty on a clock edge. It is cleared only by reset and never affects pointers.
- Undefined: underflow is tied to 0 and no register is inferred.

Test Plan:
All scenarios use DEPTH=3, SYNC_STAGES=2, AE_LEVEL=2.
- Reset asserted, then released with wr_ptr_wr=0 -> empty=1, almost_empty=1, rd_ptr_rd=0000, rd_addr=0, rd_count=0, underflow=0; reset assertion mid-clock clears outputs without waiting for a clock edge.
- wr_ptr_wr changes 0000->0001 (Gray 1), rd_en=0 -> empty falls and rd_count=1 on the 3rd rising clk_in edge after the change, not earlier; almost_empty stays 1.
- rd_en=1 held for 3 cycles while wr_ptr_wr=0000 -> rd_fire=0, rd_ptr_rd stays 0000; with RD_UNDERFLOW_EN underflow=1 and sticky until reset, without it underflow=0.
- wr_ptr_wr=1100 (bin 8, full), then rd_en=1 for 8 cycles -> rd_addr steps 0..7, rd_count steps 8..0, almost_empty rises when count reaches 2, empty rises on the edge accepting the 8th read, rd_ptr_rd=1100.
- Continue writes/reads until pointer bin 15->0 -> rd_ptr_rd goes 1000->0000 (single-bit change), rd_addr 7->0, empty/count remain correct across the wrap.
- Last read accepted on the same edge wsync advances by one -> empty stays 0, rd_count=1, next read accepted without a bubble.

Source files
------------

// File: rtl/rd_ptr_empty.sv
// Read-side pointer and empty-flag controller for a dual-clock FIFO.
// Optional sticky underflow flag is enabled by defining RD_UNDERFLOW_EN.
module rd_ptr_empty #(
    parameter int unsigned DEPTH       = 7,
    parameter int unsigned SYNC_STAGES = 2,   // legal values: 2 or 3
    parameter int unsigned AE_LEVEL    = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [DEPTH:0]   wr_ptr_wr,
    output logic [DEPTH:0]   rd_ptr_rd,
    output logic [DEPTH-1:0] rd_addr,
    output logic             rd_fire,
    output logic             empty,
    output logic             almost_empty,
    output logic [DEPTH:0]   rd_count,
    output logic             underflow
);

    localparam int unsigned PW = DEPTH + 1;

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wsync;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] fill_next;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain bringing the Gray write pointer into the read domain.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_wr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wsync = sync_q[SYNC_STAGES-1];
    assign wbin  = gray2bin(wsync);

    assign rd_fire      = rd_en & ~empty;
    assign rd_bin_next  = rd_bin + PW'(rd_fire);
    assign rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next;
    assign fill_next    = wbin - rd_bin_next;
    assign rd_addr      = rd_bin[DEPTH-1:0];

    // Flags look ahead at the post-read pointer so the last read empties with no bubble.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rd_bin       <= '0;
            rd_ptr_rd    <= '0;
            rd_count     <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_ptr_rd    <= rd_gray_next;
            rd_count     <= fill_next;
            empty        <= (rd_gray_next == wsync);
            almost_empty <= (fill_next <= PW'(AE_LEVEL));
        end
    end

`ifdef RD_UNDERFLOW_EN
    // Sticky: records any read attempted while empty, cleared only by reset.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            underflow <= 1'b0;
        end else if (rd_en && empty) begin
            underflow <= 1'b1;
        end
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Directed bench for rd_ptr_empty with DEPTH=3, SYNC_STAGES=2, AE_LEVEL=2.
module tb_rd_ptr_empty;

`ifdef RD_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       reset;
    logic       rd_en;
    logic [3:0] wr_ptr_wr;
    logic [3:0] rd_ptr_rd;
    logic [2:0] rd_addr;
    logic       rd_fire;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_count;
    logic       underflow;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_in = ~clk_in;

    rd_ptr_empty #(
        .DEPTH(3),
        .SYNC_STAGES(2),
        .AE_LEVEL(2)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .rd_en(rd_en),
        .wr_ptr_wr(wr_ptr_wr),
        .rd_ptr_rd(rd_ptr_rd),
        .rd_addr(rd_addr),
        .rd_fire(rd_fire),
        .empty(empty),
        .almost_empty(almost_empty),
        .rd_count(rd_count),
        .underflow(underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        rd_en     = 1'b0;
        wr_ptr_wr = 4'b0000;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Reset values
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_ptr", 32'(rd_ptr_rd), 32'h0);
        check("rst_addr", 32'(rd_addr), 32'h0);
        check("rst_count", 32'(rd_count), 32'h0);
        check("rst_uf", 32'(underflow), 32'd0);

        // Reads while empty: no advance; underflow only with the feature
        rd_en = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("uf_fire", 32'(rd_fire), 32'd0);
            step();
            check("uf_ptr", 32'(rd_ptr_rd), 32'h0);
        end
        rd_en = 1'b0;
        step();
        check("uf_set", 32'(underflow), 32'(UF_EN));
        step();
        check("uf_sticky", 32'(underflow), 32'(UF_EN));

        // Write pointer 0->1: empty falls exactly on the 3rd edge
        wr_ptr_wr = 4'b0001;
        step();
        check("lat_e1", 32'(empty), 32'd1);
        step();
        check("lat_e2", 32'(empty), 32'd1);
        check("lat_e2_cnt", 32'(rd_count), 32'h0);
        step();
        check("lat_e3", 32'(empty), 32'd0);
        check("lat_cnt", 32'(rd_count), 32'h1);
        check("lat_ae", 32'(almost_empty), 32'd1);

        // Asynchronous reset in the middle of a clock phase
        #3;
        reset     = 1'b0;
        wr_ptr_wr = 4'b0000;
        #1;
        check("async_empty", 32'(empty), 32'd1);
        check("async_cnt", 32'(rd_count), 32'h0);
        check("async_uf", 32'(underflow), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Fill to 8 (Gray 1100), then drain 8 reads
        wr_ptr_wr = 4'b1100;
        repeat (3) step();
        check("full_cnt", 32'(rd_count), 32'h8);
        check("full_empty", 32'(empty), 32'd0);
        check("full_ae", 32'(almost_empty), 32'd0);
        rd_en = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("drain_addr", 32'(rd_addr), 32'(i));
            check("drain_fire", 32'(rd_fire), 32'd1);
            step();
            check("drain_cnt", 32'(rd_count), 32'(7 - i));
            check("drain_ae", 32'(almost_empty), 32'((7 - i) <= 2));
            check("drain_empty", 32'(empty), 32'(i == 7));
        end
        rd_en = 1'b0;
        check("drain_ptr", 32'(rd_ptr_rd), 32'hC);

        // Write to bin 15 (Gray 1000), read up to 15
        wr_ptr_wr = 4'b1000;
        repeat (3) step();
        check("w15_cnt", 32'(rd_count), 32'h7);
        rd_en = 1'b1;
        repeat (7) step();
        rd_en = 1'b0;
        check("r15_ptr", 32'(rd_ptr_rd), 32'h8);
        check("r15_empty", 32'(empty), 32'd1);
        check("r15_addr", 32'(rd_addr), 32'h7);

        // Write wraps to bin 1 (Gray 0001): fill 2 across the wrap
        wr_ptr_wr = 4'b0001;
        repeat (3) step();
        check("wrap_cnt", 32'(rd_count), 32'h2);
        check("wrap_empty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        step();
        check("wrap_ptr", 32'(rd_ptr_rd), 32'h0);
        check("wrap_addr", 32'(rd_addr), 32'h0);
        check("wrap_cnt1", 32'(rd_count), 32'h1);
        check("wrap_empty1", 32'(empty), 32'd0);
        step();
        rd_en = 1'b0;
        check("wrap_ptr1", 32'(rd_ptr_rd), 32'h1);
        check("wrap_empty2", 32'(empty), 32'd1);

        // One entry (bin 2), then last read coincides with new write reaching wsync
        wr_ptr_wr = 4'b0011;
        repeat (3) step();
        check("sim_cnt0", 32'(rd_count), 32'h1);
        wr_ptr_wr = 4'b0010;
        step();
        step();
        check("sim_cnt_pre", 32'(rd_count), 32'h1);
        rd_en = 1'b1;
        #1;
        check("sim_fire", 32'(rd_fire), 32'd1);
        step();
        check("sim_empty", 32'(empty), 32'd0);
        check("sim_cnt", 32'(rd_count), 32'h1);
        check("sim_fire2", 32'(rd_fire), 32'd1);
        step();
        rd_en = 1'b0;
        check("sim_ptr", 32'(rd_ptr_rd), 32'h2);
        check("sim_empty2", 32'(empty), 32'd1);
        check("sim_cnt2", 32'(rd_count), 32'h0);
        check("end_uf", 32'(underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
